fetch_unit: RTL and testbench

//  Instruction-fetch stage directly upstream of the instruction decoder. Owns the PC and

---
 rtl/fetch_unit_if.sv | 37 +++
 rtl/fetch_unit.sv | 113 +++++++++++
 tb/tb_fetch_unit.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/fetch_unit_if.sv
// Bus bundle between the fetch stage, instruction memory and the decoder.
// master = fetch unit side, slave = memory/decode/execute side.
interface fetch_unit_if #(
  parameter int ADDR_W = 32
);
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ack;
  logic [31:0]       imem_rdata;
  logic              instr_valid;
  logic              instr_ready;
  logic [31:0]       instr;
  logic [ADDR_W-1:0] instr_pc;
  logic [ADDR_W-1:0] pc_plus8;
  logic [3:0]        cond;
  logic [1:0]        op;
  logic [5:0]        funct;
  logic [3:0]        rd;
  logic              redirect;
  logic [ADDR_W-1:0] redirect_pc;

  modport master (
    output imem_req, imem_addr,
    input  imem_ack, imem_rdata,
    output instr_valid, instr, instr_pc, pc_plus8, cond, op, funct, rd,
    input  instr_ready,
    input  redirect, redirect_pc
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_ack, imem_rdata,
    input  instr_valid, instr, instr_pc, pc_plus8, cond, op, funct, rd,
    output instr_ready,
    output redirect, redirect_pc
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues one-outstanding word fetches and
// queues returned words with their PC in a 2-entry FIFO ahead of decode.
module fetch_unit #(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic         clk,
  input  logic         reset,
  fetch_unit_if.master bus
);

  typedef enum logic {FETCH, DRAIN} state_t;

  state_t            state_reg, state_next;
  logic              imem_req_reg, imem_req_next;
  logic [ADDR_W-1:0] imem_addr_reg, imem_addr_next;
  logic [ADDR_W-1:0] fetch_pc_reg, fetch_pc_next;
  logic [1:0]        count_reg, count_next;
  logic              rd_ptr_reg, rd_ptr_next;
  logic              wr_ptr_reg, wr_ptr_next;

  logic [31:0]       word_reg [2];
  logic [ADDR_W-1:0] pc_reg   [2];

  logic xfer;
  logic outstanding;
  logic push;
  logic pop;
  logic head_valid;

  assign head_valid  = (count_reg != 2'd0);
  assign xfer        = imem_req_reg & bus.imem_ack;
  assign outstanding = imem_req_reg & ~bus.imem_ack;
  assign push        = xfer & (state_reg == FETCH) & ~bus.redirect;
  assign pop         = head_valid & bus.instr_ready;

  always_comb begin
    state_next     = state_reg;
    fetch_pc_next  = fetch_pc_reg;
    count_next     = count_reg;
    rd_ptr_next    = rd_ptr_reg;
    wr_ptr_next    = wr_ptr_reg;
    imem_req_next  = 1'b0;
    imem_addr_next = imem_addr_reg;

    if (bus.redirect) begin
      count_next    = 2'd0;
      rd_ptr_next   = 1'b0;
      wr_ptr_next   = 1'b0;
      fetch_pc_next = {bus.redirect_pc[ADDR_W-1:2], 2'b00};
      // A request still waiting on memory keeps its address; its data is dropped in DRAIN.
      state_next    = outstanding ? DRAIN : FETCH;
    end else begin
      count_next  = count_reg + 2'(push) - 2'(pop);
      rd_ptr_next = rd_ptr_reg ^ pop;
      wr_ptr_next = wr_ptr_reg ^ push;
      if (xfer && state_reg == FETCH)
        fetch_pc_next = fetch_pc_reg + ADDR_W'(4);
      if (xfer && state_reg == DRAIN)
        state_next = FETCH;
    end

    // An in-flight request already reserves a slot, so only issue when one is free.
    imem_req_next  = outstanding | (count_next < 2'd2);
    imem_addr_next = outstanding ? imem_addr_reg : fetch_pc_next;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= FETCH;
      fetch_pc_reg  <= RESET_PC;
      imem_req_reg  <= 1'b0;
      imem_addr_reg <= RESET_PC;
      count_reg     <= 2'd0;
      rd_ptr_reg    <= 1'b0;
      wr_ptr_reg    <= 1'b0;
    end else begin
      state_reg     <= state_next;
      fetch_pc_reg  <= fetch_pc_next;
      imem_req_reg  <= imem_req_next;
      imem_addr_reg <= imem_addr_next;
      count_reg     <= count_next;
      rd_ptr_reg    <= rd_ptr_next;
      wr_ptr_reg    <= wr_ptr_next;
    end
  end

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_entry
      always_ff @(posedge clk) begin
        if (reset) begin
          word_reg[gi] <= '0;
          pc_reg[gi]   <= '0;
        end else if (push && wr_ptr_reg == 1'(gi)) begin
          word_reg[gi] <= bus.imem_rdata;
          pc_reg[gi]   <= imem_addr_reg;
        end
      end
    end
  endgenerate

  assign bus.imem_req    = imem_req_reg;
  assign bus.imem_addr   = imem_addr_reg;
  assign bus.instr_valid = head_valid;
  assign bus.instr       = head_valid ? word_reg[rd_ptr_reg] : 32'd0;
  assign bus.instr_pc    = head_valid ? pc_reg[rd_ptr_reg] : '0;
  assign bus.pc_plus8    = head_valid ? pc_reg[rd_ptr_reg] + ADDR_W'(8) : '0;
  assign bus.cond        = bus.instr[31:28];
  assign bus.op          = bus.instr[27:26];
  assign bus.funct       = bus.instr[25:20];
  assign bus.rd          = bus.instr[15:12];

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: sequential fetch, backpressure, redirects
// (drain, same-cycle ack, address wrap) and reset mid-operation.
module tb_fetch_unit;

  logic clk;
  logic reset;
  int   tests_run;
  int   tests_failed;

  fetch_unit_if #(.ADDR_W(32)) bus ();

  fetch_unit #(.ADDR_W(32), .RESET_PC(32'h0)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.master)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {16'hE082, 4'h1, a[11:2], 2'b11};
  endfunction

  assign bus.imem_rdata = mem_word(bus.imem_addr);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    tick();
    tick();
    tests_run++; if (bus.imem_req !== 1'b0) begin tests_failed++; $display("FAIL reset_req: got %b want 0", bus.imem_req); end
    tests_run++; if (bus.imem_addr !== 32'h0) begin tests_failed++; $display("FAIL reset_addr: got %h want 0", bus.imem_addr); end
    tests_run++; if (bus.instr_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid: got %b want 0", bus.instr_valid); end
    tests_run++; if (bus.instr !== 32'h0 || bus.instr_pc !== 32'h0 || bus.pc_plus8 !== 32'h0) begin tests_failed++; $display("FAIL reset_head: got instr=%h pc=%h pc8=%h want 0", bus.instr, bus.instr_pc, bus.pc_plus8); end
    $display("[TB] reset: req=%b addr=%h valid=%b", bus.imem_req, bus.imem_addr, bus.instr_valid);
  endtask

  task automatic test_sequential;
    reset = 1'b0; bus.imem_ack = 1'b1; bus.instr_ready = 1'b1;
    tick();
    tests_run++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0) begin tests_failed++; $display("FAIL seq_first_req: got req=%b addr=%h want 1/0", bus.imem_req, bus.imem_addr); end
    tests_run++; if (bus.instr_valid !== 1'b0) begin tests_failed++; $display("FAIL seq_valid_early: got %b want 0", bus.instr_valid); end
    tick();
    tests_run++; if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 32'h0 || bus.instr !== 32'hE0821003) begin tests_failed++; $display("FAIL seq_first_instr: got v=%b pc=%h instr=%h want 1/0/e0821003", bus.instr_valid, bus.instr_pc, bus.instr); end
    tests_run++; if (bus.cond !== 4'hE || bus.op !== 2'h0 || bus.funct !== 6'h08 || bus.rd !== 4'h1) begin tests_failed++; $display("FAIL seq_fields: got cond=%h op=%h funct=%h rd=%h want e/0/08/1", bus.cond, bus.op, bus.funct, bus.rd); end
    tests_run++; if (bus.pc_plus8 !== 32'h8 || bus.imem_addr !== 32'h4) begin tests_failed++; $display("FAIL seq_pc8_addr: got pc8=%h addr=%h want 8/4", bus.pc_plus8, bus.imem_addr); end
    for (int k = 1; k <= 5; k++) begin
      tick();
      tests_run++; if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 32'(4*k) || bus.instr !== mem_word(32'(4*k)) || bus.imem_addr !== 32'(4*k+4) || bus.imem_req !== 1'b1) begin tests_failed++; $display("FAIL seq_stream%0d: got v=%b pc=%h instr=%h addr=%h req=%b want pc=%h", k, bus.instr_valid, bus.instr_pc, bus.instr, bus.imem_addr, bus.imem_req, 32'(4*k)); end
      $display("[TB] seq: instr_pc=%h instr=%h next_addr=%h", bus.instr_pc, bus.instr, bus.imem_addr);
    end
  endtask

  task automatic test_backpressure;
    bus.instr_ready = 1'b0;
    tick();
    tests_run++; if (bus.imem_req !== 1'b0 || bus.instr_pc !== 32'h14) begin tests_failed++; $display("FAIL bp_full: got req=%b pc=%h want 0/14", bus.imem_req, bus.instr_pc); end
    tick();
    tests_run++; if (bus.imem_req !== 1'b0 || bus.instr_pc !== 32'h14 || bus.instr_valid !== 1'b1) begin tests_failed++; $display("FAIL bp_hold: got req=%b pc=%h v=%b want 0/14/1", bus.imem_req, bus.instr_pc, bus.instr_valid); end
    bus.instr_ready = 1'b1;
    tick();
    bus.instr_ready = 1'b0;
    tests_run++; if (bus.instr_pc !== 32'h18 || bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h1C) begin tests_failed++; $display("FAIL bp_one_pop: got pc=%h req=%b addr=%h want 18/1/1c", bus.instr_pc, bus.imem_req, bus.imem_addr); end
    tick();
    tests_run++; if (bus.imem_req !== 1'b0 || bus.instr_pc !== 32'h18) begin tests_failed++; $display("FAIL bp_refill: got req=%b pc=%h want 0/18", bus.imem_req, bus.instr_pc); end
    bus.instr_ready = 1'b1;
    tick();
    tests_run++; if (bus.instr_pc !== 32'h1C || bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h20) begin tests_failed++; $display("FAIL bp_order: got pc=%h req=%b addr=%h want 1c/1/20", bus.instr_pc, bus.imem_req, bus.imem_addr); end
    $display("[TB] backpressure: head=%h next_addr=%h", bus.instr_pc, bus.imem_addr);
  endtask

  task automatic test_redirect_drain;
    reset = 1'b1; bus.imem_ack = 1'b0;
    tick();
    reset = 1'b0; bus.redirect = 1'b1; bus.redirect_pc = 32'h10;
    tick();
    bus.redirect = 1'b0;
    tests_run++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h10) begin tests_failed++; $display("FAIL drain_setup: got req=%b addr=%h want 1/10", bus.imem_req, bus.imem_addr); end
    tick();
    tick();
    bus.redirect = 1'b1; bus.redirect_pc = 32'h103;
    tick();
    bus.redirect = 1'b0;
    tests_run++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h10) begin tests_failed++; $display("FAIL drain_addr_hold: got req=%b addr=%h want 1/10", bus.imem_req, bus.imem_addr); end
    bus.imem_ack = 1'b1;
    tick();
    tests_run++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h100 || bus.instr_valid !== 1'b0) begin tests_failed++; $display("FAIL drain_retarget: got req=%b addr=%h v=%b want 1/100/0", bus.imem_req, bus.imem_addr, bus.instr_valid); end
    tick();
    tests_run++; if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 32'h100) begin tests_failed++; $display("FAIL drain_landed: got v=%b pc=%h want 1/100", bus.instr_valid, bus.instr_pc); end
    $display("[TB] redirect drain: head=%h next_addr=%h", bus.instr_pc, bus.imem_addr);
  endtask

  task automatic test_redirect_ack;
    bus.redirect = 1'b1; bus.redirect_pc = 32'h200;
    tick();
    bus.redirect = 1'b0;
    tests_run++; if (bus.instr_valid !== 1'b0 || bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h200) begin tests_failed++; $display("FAIL redir_ack: got v=%b req=%b addr=%h want 0/1/200", bus.instr_valid, bus.imem_req, bus.imem_addr); end
    tick();
    tests_run++; if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 32'h200 || bus.instr !== mem_word(32'h200)) begin tests_failed++; $display("FAIL redir_ack_land: got v=%b pc=%h instr=%h want 1/200", bus.instr_valid, bus.instr_pc, bus.instr); end
    $display("[TB] redirect with ack: head=%h", bus.instr_pc);
  endtask

  task automatic test_wrap;
    bus.redirect = 1'b1; bus.redirect_pc = 32'hFFFF_FFFE;
    tick();
    bus.redirect = 1'b0;
    tests_run++; if (bus.imem_addr !== 32'hFFFF_FFFC || bus.instr_valid !== 1'b0) begin tests_failed++; $display("FAIL wrap_addr: got addr=%h v=%b want fffffffc/0", bus.imem_addr, bus.instr_valid); end
    tick();
    tests_run++; if (bus.instr_pc !== 32'hFFFF_FFFC || bus.pc_plus8 !== 32'h4 || bus.instr !== 32'hE0821FFF || bus.imem_addr !== 32'h0) begin tests_failed++; $display("FAIL wrap_top: got pc=%h pc8=%h instr=%h addr=%h want fffffffc/4/e0821fff/0", bus.instr_pc, bus.pc_plus8, bus.instr, bus.imem_addr); end
    tick();
    tests_run++; if (bus.instr_pc !== 32'h0 || bus.pc_plus8 !== 32'h8 || bus.imem_addr !== 32'h4) begin tests_failed++; $display("FAIL wrap_zero: got pc=%h pc8=%h addr=%h want 0/8/4", bus.instr_pc, bus.pc_plus8, bus.imem_addr); end
    $display("[TB] wrap: head=%h pc_plus8=%h", bus.instr_pc, bus.pc_plus8);
  endtask

  task automatic test_reset_mid;
    bus.imem_ack = 1'b0; bus.instr_ready = 1'b0;
    tick();
    tests_run++; if (bus.instr_valid !== 1'b1 || bus.imem_req !== 1'b1) begin tests_failed++; $display("FAIL rstmid_pre: got v=%b req=%b want 1/1", bus.instr_valid, bus.imem_req); end
    reset = 1'b1; bus.imem_ack = 1'b1;
    tick();
    reset = 1'b0;
    tests_run++; if (bus.imem_req !== 1'b0 || bus.imem_addr !== 32'h0 || bus.instr_valid !== 1'b0) begin tests_failed++; $display("FAIL rstmid_ctl: got req=%b addr=%h v=%b want 0/0/0", bus.imem_req, bus.imem_addr, bus.instr_valid); end
    tests_run++; if (bus.instr !== 32'h0 || bus.instr_pc !== 32'h0 || bus.pc_plus8 !== 32'h0 || bus.cond !== 4'h0 || bus.rd !== 4'h0) begin tests_failed++; $display("FAIL rstmid_head: got instr=%h pc=%h pc8=%h want 0", bus.instr, bus.instr_pc, bus.pc_plus8); end
    tick();
    tests_run++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0 || bus.instr_valid !== 1'b0) begin tests_failed++; $display("FAIL rstmid_restart: got req=%b addr=%h v=%b want 1/0/0", bus.imem_req, bus.imem_addr, bus.instr_valid); end
    bus.instr_ready = 1'b1;
    tick();
    tests_run++; if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 32'h0) begin tests_failed++; $display("FAIL rstmid_first: got v=%b pc=%h want 1/0", bus.instr_valid, bus.instr_pc); end
    $display("[TB] reset mid-run: head=%h next_addr=%h", bus.instr_pc, bus.imem_addr);
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    reset = 1'b1;
    bus.imem_ack = 1'b0;
    bus.instr_ready = 1'b0;
    bus.redirect = 1'b0;
    bus.redirect_pc = 32'h0;
    test_reset();
    test_sequential();
    test_backpressure();
    test_redirect_drain();
    test_redirect_ack();
    test_wrap();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
